// File: rtl/btn_dir_ctrl_pkg.sv
// Shared game package: one-hot direction encodings used by the button
// controller, game logic and drawing, plus the button index map and the
// direction priority resolver.
package btn_dir_ctrl_pkg;

    // One-hot requested direction, bit3=up .. bit0=right.
    typedef enum logic [3:0] {
        DIR_NONE  = 4'b0000,
        DIR_RIGHT = 4'b0001,
        DIR_LEFT  = 4'b0010,
        DIR_DOWN  = 4'b0100,
        DIR_UP    = 4'b1000
    } dir_e;

    // Bit positions inside the 5-bit button vectors {u,d,l,r,c}.
    localparam int BTN_N = 5;
    localparam int BTN_U = 4;
    localparam int BTN_D = 3;
    localparam int BTN_L = 2;
    localparam int BTN_R = 1;
    localparam int BTN_C = 0;

    // Resolve this cycle's direction presses {u,d,l,r} into the next
    // requested direction. Priority is up > down > left > right; with no
    // direction press the current request is kept.
    function automatic dir_e dir_from_press(input logic [3:0] press, input dir_e cur);
        dir_e res;
        if (press[3]) begin
            res = DIR_UP;
        end else if (press[2]) begin
            res = DIR_DOWN;
        end else if (press[1]) begin
            res = DIR_LEFT;
        end else if (press[0]) begin
            res = DIR_RIGHT;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer, debounce counter and
// registered level/rising-edge pulse.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   btn        : raw asynchronous button, active-high
//   level      : debounced level
//   press      : one-cycle pulse on the edge where level rises
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    // Terminal count: the DB_CYCLES-th consecutive mismatching sample.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_r;
    logic [DB_W-1:0] cnt_r;
    logic            level_r;
    logic            press_r;

    // Synchronizer, mismatch counter and level/pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= 2'b00;
            cnt_r   <= {DB_W{1'b0}};
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], btn};
            if (sync_r[1] != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    // Mismatch held long enough: accept it and restart.
                    level_r <= ~level_r;
                    cnt_r   <= {DB_W{1'b0}};
                    press_r <= ~level_r;
                end else begin
                    cnt_r   <= cnt_r + DB_W'(1);
                    press_r <= 1'b0;
                end
            end else begin
                // Any agreeing sample is a bounce: counting restarts.
                cnt_r   <= {DB_W{1'b0}};
                press_r <= 1'b0;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/btn_dir_ctrl.sv
// Push-button front end for the game: debounces the five buttons, keeps a
// sticky one-hot requested direction and a pause flag toggled by centre.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   btn_u/d/l/r/c                : raw asynchronous buttons, active-high
//   btn_level[4:0]               : debounced levels {u,d,l,r,c}
//   btn_press[4:0]               : rising-edge pulses, same order
//   dir_req[3:0]                 : sticky one-hot direction {up,down,left,right}
//   dir_new                      : one-cycle pulse when dir_req changes
//   paused                       : pause flag
module btn_dir_ctrl
    import btn_dir_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [3:0] dir_req,
    output logic       dir_new,
    output logic       paused
);

    logic [BTN_N-1:0] btn_raw_s;
    logic [BTN_N-1:0] btn_level_s;
    logic [BTN_N-1:0] btn_press_s;
    dir_e             dir_nxt_s;
    dir_e             dir_req_r;
    logic             dir_new_r;
    logic             paused_r;

    assign btn_raw_s = {btn_u, btn_d, btn_l, btn_r, btn_c};

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw_s[i]),
            .level (btn_level_s[i]),
            .press (btn_press_s[i])
        );
    end

    // Next requested direction from this cycle's direction presses.
    always_comb begin
        dir_nxt_s = dir_from_press(btn_press_s[BTN_U:BTN_R], dir_req_r);
    end

    // Direction request, change pulse and pause flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_req_r <= DIR_NONE;
            dir_new_r <= 1'b0;
            paused_r  <= 1'b0;
        end else begin
            dir_req_r <= dir_nxt_s;
            // Re-pressing the held direction is not a change.
            dir_new_r <= (dir_nxt_s != dir_req_r);
            paused_r  <= paused_r ^ btn_press_s[BTN_C];
        end
    end

    assign btn_level = btn_level_s;
    assign btn_press = btn_press_s;
    assign dir_req   = dir_req_r;
    assign dir_new   = dir_new_r;
    assign paused    = paused_r;

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Self-checking bench for btn_dir_ctrl with DB_CYCLES=4: a table of
// held-input vectors, hand-written pulse-timing sequences and random
// stimulus, all checked against a window-based reference model.
module tb_btn_dir_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
    logic [4:0] btn_level, btn_press;
    logic [3:0] dir_req;
    logic       dir_new, paused;

    int n_tests = 0;
    int n_fail  = 0;

    btn_dir_ctrl #(.DB_CYCLES(DB), .DB_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .btn_c     (btn_c),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .dir_req   (dir_req),
        .dir_new   (dir_new),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last DB synchronized samples
    // (the raw input two edges earlier, zero right after reset) all
    // disagree with it. Direction/pause react one edge after a press.
    logic [4:0] m_level, m_press, m_raw_hist[$], m_samp_hist[$];
    logic [3:0] m_dir;
    logic       m_new, m_paused;

    task automatic model_edge(input logic r, input logic [4:0] b);
        logic [3:0] nd;
        logic [4:0] samp;
        logic       all_diff;
        if (r) begin
            m_level = 5'b0; m_press = 5'b0; m_dir = 4'b0; m_new = 1'b0; m_paused = 1'b0;
            m_raw_hist.delete();
            m_samp_hist.delete();
        end else begin
            nd = m_dir;
            if (m_press[4])      nd = 4'b1000;
            else if (m_press[3]) nd = 4'b0100;
            else if (m_press[2]) nd = 4'b0010;
            else if (m_press[1]) nd = 4'b0001;
            m_new    = (nd != m_dir);
            m_dir    = nd;
            m_paused = m_paused ^ m_press[0];
            m_raw_hist.push_back(b);
            if (m_raw_hist.size() > 3) void'(m_raw_hist.pop_front());
            samp = (m_raw_hist.size() == 3) ? m_raw_hist[0] : 5'b0;
            m_samp_hist.push_back(samp);
            if (m_samp_hist.size() > DB) void'(m_samp_hist.pop_front());
            for (int i = 0; i < 5; i++) begin
                all_diff = (m_samp_hist.size() == DB);
                foreach (m_samp_hist[j]) if (m_samp_hist[j][i] == m_level[i]) all_diff = 1'b0;
                m_press[i] = 1'b0;
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    m_press[i] = m_level[i];
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock edge with inputs b ({u,d,l,r,c}), then compare with the model.
    task automatic step(input logic r, input logic [4:0] b);
        rst = r;
        {btn_u, btn_d, btn_l, btn_r, btn_c} = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        check("model", {16'b0, btn_level, btn_press, dir_req, dir_new, paused},
              {16'b0, m_level, m_press, m_dir, m_new, m_paused});
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] btn;
        int         cycles;
        logic [4:0] lvl;
        logic [3:0] dir;
        logic       paused;
    } vec_t;

    vec_t tbl[$];
    int   cnt;
    logic r_s;
    logic [4:0] b_s;

    initial begin
        tbl.push_back('{1'b1, 5'b00000,  2, 5'b00000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 5'b00010, 10, 5'b00010, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 10, 5'b00000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 5'b10000,  3, 5'b00000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 10, 5'b00000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 5'b01100, 10, 5'b01100, 4'b0100, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 10, 5'b00000, 4'b0100, 1'b0});
        tbl.push_back('{1'b0, 5'b00001, 10, 5'b00001, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 5'b00000, 10, 5'b00000, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 5'b00001, 10, 5'b00001, 4'b0100, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 10, 5'b00000, 4'b0100, 1'b0});
        tbl.push_back('{1'b0, 5'b00010, 10, 5'b00010, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 5'b00010,  1, 5'b00000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 5'b00010,  5, 5'b00000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 5'b00010,  1, 5'b00010, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 5'b00010,  1, 5'b00010, 4'b0001, 1'b0});

        for (int v = 0; v < tbl.size(); v++) begin
            for (int c = 0; c < tbl[v].cycles; c++) step(tbl[v].rst, tbl[v].btn);
            check($sformatf("tbl%0d_level", v), {27'b0, btn_level}, {27'b0, tbl[v].lvl});
            check($sformatf("tbl%0d_dir", v), {28'b0, dir_req}, {28'b0, tbl[v].dir});
            check($sformatf("tbl%0d_paused", v), {31'b0, paused}, {31'b0, tbl[v].paused});
        end

        // btn_r held from reset: press at edge 6, dir_new at edge 7 only.
        step(1'b1, 5'b0); step(1'b1, 5'b0);
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 5'b00010);
            check($sformatf("r_press_e%0d", e), {27'b0, btn_press}, (e == 6) ? 32'd2 : 32'd0);
            check($sformatf("r_dirnew_e%0d", e), {31'b0, dir_new}, (e == 7) ? 32'd1 : 32'd0);
            check($sformatf("r_dir_e%0d", e), {28'b0, dir_req}, (e >= 7) ? 32'd1 : 32'd0);
        end

        // Release and re-press of the held direction: no change, no pulse.
        cnt = 0;
        for (int e = 0; e < 8; e++) begin step(1'b0, 5'b0); cnt += int'(dir_new); end
        for (int e = 0; e < 8; e++) begin step(1'b0, 5'b00010); cnt += int'(dir_new); end
        check("repress_dirnew", 32'(cnt), 32'd0);
        check("repress_dir", {28'b0, dir_req}, 32'd1);

        // Down and left together: down wins, one dir_new pulse.
        for (int e = 0; e < 8; e++) step(1'b0, 5'b0);
        cnt = 0;
        for (int e = 0; e < 8; e++) begin step(1'b0, 5'b01100); cnt += int'(dir_new); end
        check("dl_dirnew_count", 32'(cnt), 32'd1);
        check("dl_dir", {28'b0, dir_req}, 32'd4);

        // Reset mid-count with btn_u counter part-way, then recount from 0.
        for (int e = 0; e < 8; e++) step(1'b0, 5'b0);
        for (int e = 0; e < 4; e++) step(1'b0, 5'b10000);
        step(1'b1, 5'b10000);
        check("midrst_outputs", {16'b0, btn_level, btn_press, dir_req, dir_new, paused}, 32'd0);
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 5'b10000);
            check($sformatf("u_level_e%0d", e), {31'b0, btn_level[4]}, (e >= 6) ? 32'd1 : 32'd0);
            check($sformatf("u_dir_e%0d", e), {28'b0, dir_req}, (e >= 7) ? 32'd8 : 32'd0);
        end

        // Two centre presses: paused toggles one edge after each press pulse.
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 8; e++) step(1'b0, 5'b0);
            for (int e = 1; e <= 8; e++) begin
                step(1'b0, 5'b00001);
                check($sformatf("c%0d_press_e%0d", k, e), {31'b0, btn_press[0]}, (e == 6) ? 32'd1 : 32'd0);
                check($sformatf("c%0d_paused_e%0d", k, e), {31'b0, paused},
                      ((e >= 7) ? 32'd1 : 32'd0) ^ 32'(k));
            end
        end

        // Random held segments, short glitches and occasional resets.
        for (int s = 0; s < 600; s++) begin
            r_s = ($urandom_range(0, 29) == 0);
            b_s = 5'($urandom);
            if (r_s) begin
                step(1'b1, b_s);
            end else begin
                for (int c = 0; c < int'($urandom_range(1, 9)); c++) step(1'b0, b_s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
